hwacc_cm_cxt_rsp_reorder: RTL and testbench
===========================================

Name: hwacc_cm_cxt_rsp_reorder

Overview:
- Stage directly downstream of the thread that merges QPC/CQC/EQC into one context word per request tag.
- Combined responses arrive tagged and can be out of order, because EQC cache hits and misses resolve at different times.
- The block buffers each response by tag and releases responses strictly in tag-allocation order, which is the ascending tag sequence with modulo wrap.
- On each delivery it returns the tag to the upstream tag allocator.

Parameters:
- REQ_TAG_NUM, 32: number of request tags and buffer slots; must be a power of 2.
- REQ_TAG_NUM_LOG, 5: log2(REQ_TAG_NUM).
- CXT_DATA_WIDTH, 1024: width of the combined {EQC, CQC, QPC} context word.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- cxt_combine_valid, input, 1: combined context valid.
- cxt_combine_head, input, REQ_TAG_NUM_LOG: request tag of the combined context.
- cxt_combine_data, input, CXT_DATA_WIDTH: combined context word.
- cxt_combine_ready, output, 1: accept.
- cxt_rsp_valid, output, 1: in-order response valid.
- cxt_rsp_head, output, REQ_TAG_NUM_LOG: tag of the response.
- cxt_rsp_data, output, CXT_DATA_WIDTH: response data.
- cxt_rsp_ready, input, 1: consumer accept.
- tag_free_valid, output, 1: one-cycle pulse; tag returned to the allocator.
- tag_free_idx, output, REQ_TAG_NUM_LOG: tag being freed.
- pending_cnt, output, REQ_TAG_NUM_LOG+1: number of occupied slots.
- dup_tag_err, output, 1: sticky error flag; cleared only by rst.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset (also when asserted mid-operation):
  - All slot valid bits = 0; head_ptr = 0.
  - cxt_rsp_valid/head/data = 0; tag_free_valid/idx = 0.
  - pending_cnt = 0; dup_tag_err = 0.
  - Any buffered or presented data is discarded; the allocator is resynchronised by its own reset.
- Storage: REQ_TAG_NUM slots × CXT_DATA_WIDTH, plus a valid bit per slot. Slot index = tag.
- cxt_combine_ready = 1 whenever rst = 0. A slot exists for every tag, so backpressure is never needed.
- Write: on cxt_combine_valid && ready, slot[head] <= data and valid[head] <= 1 at the next edge.
  - If valid[head] is already 1: data is dropped, the slot is unchanged, dup_tag_err <= 1, and pending_cnt is unchanged.
- Output register, states OUT_EMPTY / OUT_FULL:
  - OUT_EMPTY → OUT_FULL when valid[head_ptr] = 1. On that edge:
    - cxt_rsp_* <= {1, head_ptr, slot[head_ptr]};
    - valid[head_ptr] <= 0;
    - head_ptr <= head_ptr + 1, wrapping REQ_TAG_NUM-1 → 0.
  - OUT_FULL with cxt_rsp_ready = 1:
    - If valid[head_ptr] = 1, reload as above in the same edge and stay in OUT_FULL (back-to-back, 1 response/cycle).
    - Otherwise → OUT_EMPTY and cxt_rsp_valid <= 0.
  - OUT_FULL with cxt_rsp_ready = 0: hold all cxt_rsp_* stable.
- Tag release: on cxt_rsp handshake, tag_free_valid <= 1 and tag_free_idx <= cxt_rsp_head for exactly one cycle (registered). Otherwise tag_free_valid <= 0.
- Latency: a combine accepted at edge N with tag == head_ptr and OUT_EMPTY gives cxt_rsp_valid = 1 after edge N+1. The valid bit is visible from N; the load occurs at N+1.
- Simultaneous write and read of the same slot cannot occur, because a read requires valid = 1 and a write into a valid slot is the duplicate case. In the duplicate case the read proceeds with the old data and the write is dropped.
- pending_cnt counts slot valid bits plus the output register when full.
  - +1 on a non-duplicate write, −1 on rsp handshake; both in the same cycle leave it unchanged.
  - Maximum value = REQ_TAG_NUM.
- Wrap: head_ptr is modulo REQ_TAG_NUM. Tag 0 follows tag 31 with no bubble.

Test Plan:
- Reset, then write tag 0, data 0xA5.., with cxt_rsp_ready = 1 → cxt_rsp_valid high 1 cycle after the accept edge, head 0, data 0xA5..; the cycle after the handshake, tag_free_valid = 1 with idx 0; pending_cnt goes 0→1→0.
- Out of order: write tags 2, 1, 0 on consecutive cycles → no output until tag 0 is written; then tags 0, 1, 2 are delivered on 3 consecutive cycles, and tag_free_idx follows 0, 1, 2.
- Backpressure: fill tags 0–3 with cxt_rsp_ready = 0 → tag 0 is held stable and pending_cnt = 4; raise ready → tags 0–3 delivered back-to-back.
- Wrap: stream 40 sequential writes, tags 0..31 then 0..7, each new tag written after the previous use of that tag has been freed → 40 in-order responses, tag 0 follows 31 with no bubble, and dup_tag_err stays 0.
- Duplicate: write tag 5 twice (data X, then Y) while head_ptr = 0 → dup_tag_err = 1 and stays set; later delivery of tag 5 carries X.
- Reset mid-operation: tags 1 and 3 buffered, output stalled on tag 0, assert rst for 1 cycle → all outputs 0 and pending_cnt = 0; a new write to tag 0 is delivered normally.

Source files
------------

// File: rtl/hwacc_cm_cxt_rsp_reorder.sv
// Tag-indexed reorder buffer: combined QPC/CQC/EQC context words arrive out of
// order and are released in ascending tag order, returning each tag on delivery.
module hwacc_cm_cxt_rsp_reorder #(
  parameter int unsigned REQ_TAG_NUM     = 32,
  parameter int unsigned REQ_TAG_NUM_LOG = 5,
  parameter int unsigned CXT_DATA_WIDTH  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cxt_combine_valid,
  input  logic [REQ_TAG_NUM_LOG-1:0] cxt_combine_head,
  input  logic [CXT_DATA_WIDTH-1:0]  cxt_combine_data,
  output logic                       cxt_combine_ready,
  output logic                       cxt_rsp_valid,
  output logic [REQ_TAG_NUM_LOG-1:0] cxt_rsp_head,
  output logic [CXT_DATA_WIDTH-1:0]  cxt_rsp_data,
  input  logic                       cxt_rsp_ready,
  output logic                       tag_free_valid,
  output logic [REQ_TAG_NUM_LOG-1:0] tag_free_idx,
  output logic [REQ_TAG_NUM_LOG:0]   pending_cnt,
  output logic                       dup_tag_err
);

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  localparam logic [REQ_TAG_NUM_LOG-1:0] PTR_ONE  = 1;
  localparam logic [REQ_TAG_NUM_LOG:0]   PEND_ONE = 1;

  logic [CXT_DATA_WIDTH-1:0]  r_mem [REQ_TAG_NUM];
  logic [REQ_TAG_NUM-1:0]     r_vld;
  logic [REQ_TAG_NUM_LOG-1:0] r_head_ptr;
  out_state_t                 r_state;
  logic                       r_rsp_valid;
  logic [REQ_TAG_NUM_LOG-1:0] r_rsp_head;
  logic [CXT_DATA_WIDTH-1:0]  r_rsp_data;
  logic                       r_free_valid;
  logic [REQ_TAG_NUM_LOG-1:0] r_free_idx;
  logic [REQ_TAG_NUM_LOG:0]   r_pending;
  logic                       r_dup;

  logic                       w_wr;
  logic                       w_dup;
  logic                       w_wr_ok;
  logic                       w_hs;
  logic                       w_load;
  logic [REQ_TAG_NUM-1:0]     w_vld_nxt;

  always_comb begin
    w_wr    = cxt_combine_valid && !rst;
    w_dup   = w_wr && r_vld[cxt_combine_head];
    w_wr_ok = w_wr && !r_vld[cxt_combine_head];
    w_hs    = (r_state == OUT_FULL) && cxt_rsp_ready;
    w_load  = r_vld[r_head_ptr] && ((r_state == OUT_EMPTY) || w_hs);
    // A load needs a valid slot and a write needs an empty one, so the two never target the same bit.
    w_vld_nxt = r_vld;
    if (w_load)  w_vld_nxt[r_head_ptr]       = 1'b0;
    if (w_wr_ok) w_vld_nxt[cxt_combine_head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[cxt_combine_head] <= cxt_combine_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld        <= '0;
      r_head_ptr   <= '0;
      r_state      <= OUT_EMPTY;
      r_rsp_valid  <= 1'b0;
      r_rsp_head   <= '0;
      r_rsp_data   <= '0;
      r_free_valid <= 1'b0;
      r_free_idx   <= '0;
      r_pending    <= '0;
      r_dup        <= 1'b0;
    end else begin
      r_vld        <= w_vld_nxt;
      r_free_valid <= w_hs;
      if (w_hs)  r_free_idx <= r_rsp_head;
      if (w_dup) r_dup      <= 1'b1;

      case ({w_wr_ok, w_hs})
        2'b10:   r_pending <= r_pending + PEND_ONE;
        2'b01:   r_pending <= r_pending - PEND_ONE;
        default: r_pending <= r_pending;
      endcase

      case (r_state)
        OUT_EMPTY: begin
          if (w_load) r_state <= OUT_FULL;
        end
        OUT_FULL: begin
          if (cxt_rsp_ready && !w_load) begin
            r_state     <= OUT_EMPTY;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= OUT_EMPTY;
      endcase

      if (w_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_head  <= r_head_ptr;
        r_rsp_data  <= r_mem[r_head_ptr];
        r_head_ptr  <= r_head_ptr + PTR_ONE;
      end
    end
  end

  assign cxt_combine_ready = !rst;
  assign cxt_rsp_valid     = r_rsp_valid;
  assign cxt_rsp_head      = r_rsp_head;
  assign cxt_rsp_data      = r_rsp_data;
  assign tag_free_valid    = r_free_valid;
  assign tag_free_idx      = r_free_idx;
  assign pending_cnt       = r_pending;
  assign dup_tag_err       = r_dup;

endmodule

// File: tb/tb_hwacc_cm_cxt_rsp_reorder.sv
// Scoreboard bench for the context response reorder buffer: directed tag
// sequences push expected in-order responses; a negedge monitor pops and compares.
module tb_hwacc_cm_cxt_rsp_reorder;

  localparam int W = 1024;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         cxt_combine_valid;
  logic [L-1:0] cxt_combine_head;
  logic [W-1:0] cxt_combine_data;
  logic         cxt_combine_ready;
  logic         cxt_rsp_valid;
  logic [L-1:0] cxt_rsp_head;
  logic [W-1:0] cxt_rsp_data;
  logic         cxt_rsp_ready;
  logic         tag_free_valid;
  logic [L-1:0] tag_free_idx;
  logic [L:0]   pending_cnt;
  logic         dup_tag_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [L-1:0] head;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q [$];
  logic [L-1:0] free_q[$];

  hwacc_cm_cxt_rsp_reorder #(
    .REQ_TAG_NUM    (32),
    .REQ_TAG_NUM_LOG(L),
    .CXT_DATA_WIDTH (W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cxt_combine_valid(cxt_combine_valid),
    .cxt_combine_head (cxt_combine_head),
    .cxt_combine_data (cxt_combine_data),
    .cxt_combine_ready(cxt_combine_ready),
    .cxt_rsp_valid    (cxt_rsp_valid),
    .cxt_rsp_head     (cxt_rsp_head),
    .cxt_rsp_data     (cxt_rsp_data),
    .cxt_rsp_ready    (cxt_rsp_ready),
    .tag_free_valid   (tag_free_valid),
    .tag_free_idx     (tag_free_idx),
    .pending_cnt      (pending_cnt),
    .dup_tag_err      (dup_tag_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [31:0] w);
    return {32{w}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: free pulses for earlier handshakes are retired before new ones are queued.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && tag_free_valid) begin
      if (free_q.size() == 0) begin
        chk("free_unexpected", 64'(tag_free_idx), 64'hFFFF);
      end else begin
        chk("free_idx", 64'(tag_free_idx), 64'(free_q.pop_front()));
      end
    end
    if (!rst && cxt_rsp_valid && cxt_rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(cxt_rsp_head), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_head", 64'(cxt_rsp_head), 64'(e.head));
        checks++;
        if (cxt_rsp_data !== e.data) begin
          errors++;
          $display("FAIL rsp_data tag=%0d actual=%h expected=%h", e.head,
                   cxt_rsp_data[127:0], e.data[127:0]);
        end
        free_q.push_back(e.head);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cxt_combine_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    free_q.delete();
  endtask

  task automatic wr(input logic [L-1:0] t, input logic [W-1:0] d);
    cxt_combine_valid = 1'b1;
    cxt_combine_head  = t;
    cxt_combine_data  = d;
    @(posedge clk);
    #1 cxt_combine_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic [L-1:0] t, input logic [W-1:0] d);
    exp_t e;
    e.head = t;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || free_q.size() != 0 || pending_cnt != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n >= 300), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cxt_combine_valid = 1'b0;
    cxt_combine_head  = '0;
    cxt_combine_data  = '0;
    cxt_rsp_ready     = 1'b0;

    // Reset state and single in-order response
    @(negedge clk);
    chk("rst_ready_low", 64'(cxt_combine_ready), 64'd0);
    do_reset();
    @(negedge clk);
    chk("rst_rsp_valid", 64'(cxt_rsp_valid), 64'd0);
    chk("rst_rsp_head", 64'(cxt_rsp_head), 64'd0);
    chk("rst_rsp_data", 64'(|cxt_rsp_data), 64'd0);
    chk("rst_free_valid", 64'(tag_free_valid), 64'd0);
    chk("rst_free_idx", 64'(tag_free_idx), 64'd0);
    chk("rst_pending", 64'(pending_cnt), 64'd0);
    chk("rst_dup", 64'(dup_tag_err), 64'd0);
    chk("ready_high", 64'(cxt_combine_ready), 64'd1);
    cxt_rsp_ready = 1'b1;
    expect_rsp(0, mk(32'hA5A5A5A5));
    wr(0, mk(32'hA5A5A5A5));
    @(negedge clk);
    chk("t1_pending_1", 64'(pending_cnt), 64'd1);
    chk("t1_no_rsp_yet", 64'(cxt_rsp_valid), 64'd0);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(cxt_rsp_valid), 64'd1);
    chk("t1_pending_held", 64'(pending_cnt), 64'd1);
    @(negedge clk);
    chk("t1_pending_0", 64'(pending_cnt), 64'd0);
    chk("t1_free_pulse", 64'(tag_free_valid), 64'd1);
    chk("t1_rsp_gone", 64'(cxt_rsp_valid), 64'd0);
    drain("t1_drain");

    // Out-of-order arrival 2,1,0
    do_reset();
    cxt_rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) expect_rsp(L'(t), mk(32'h2000_0000 + t));
    wr(2, mk(32'h2000_0002));
    @(negedge clk);
    chk("oo_wait_after2", 64'(cxt_rsp_valid), 64'd0);
    wr(1, mk(32'h2000_0001));
    @(negedge clk);
    chk("oo_wait_after1", 64'(cxt_rsp_valid), 64'd0);
    wr(0, mk(32'h2000_0000));
    @(negedge clk);
    chk("oo_latency", 64'(cxt_rsp_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("oo_b2b_valid", 64'(cxt_rsp_valid), 64'd1);
    end
    drain("oo_drain");

    // Backpressure hold then back-to-back release
    do_reset();
    cxt_rsp_ready = 1'b0;
    for (int t = 0; t < 4; t++) expect_rsp(L'(t), mk(32'h3000_0000 + t));
    for (int t = 0; t < 4; t++) wr(L'(t), mk(32'h3000_0000 + t));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(cxt_rsp_valid), 64'd1);
      chk("bp_head", 64'(cxt_rsp_head), 64'd0);
      chk("bp_data", 64'(cxt_rsp_data == mk(32'h3000_0000)), 64'd1);
      chk("bp_pending", 64'(pending_cnt), 64'd4);
    end
    @(posedge clk);
    #1 cxt_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_b2b_valid", 64'(cxt_rsp_valid), 64'd1);
    end
    drain("bp_drain");

    // Wrap: 40 sequential tags, 31 -> 0 with no bubble
    do_reset();
    cxt_rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) expect_rsp(L'(i % 32), mk(32'h1000_0000 + i));
    fork
      begin
        for (int i = 0; i < 40; i++) wr(L'(i % 32), mk(32'h1000_0000 + i));
      end
      begin
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          chk("wrap_no_bubble", 64'(cxt_rsp_valid), 64'd1);
        end
      end
    join
    drain("wrap_drain");
    chk("wrap_no_dup", 64'(dup_tag_err), 64'd0);

    // Duplicate tag: first data kept, sticky error
    do_reset();
    cxt_rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) expect_rsp(L'(t), mk(32'h5000_0000 + t));
    expect_rsp(5, mk(32'hDEADBEEF));
    wr(5, mk(32'hDEADBEEF));
    wr(5, mk(32'h0BADF00D));
    @(negedge clk);
    chk("dup_flag", 64'(dup_tag_err), 64'd1);
    chk("dup_pending", 64'(pending_cnt), 64'd1);
    chk("dup_no_rsp", 64'(cxt_rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("dup_sticky", 64'(dup_tag_err), 64'd1);
    for (int t = 0; t < 5; t++) wr(L'(t), mk(32'h5000_0000 + t));
    drain("dup_drain");
    chk("dup_sticky_end", 64'(dup_tag_err), 64'd1);

    // Reset while stalled with buffered tags
    do_reset();
    cxt_rsp_ready = 1'b0;
    wr(0, mk(32'h6000_0000));
    wr(1, mk(32'h6000_0001));
    wr(3, mk(32'h6000_0003));
    repeat (2) @(negedge clk);
    chk("mid_stalled", 64'(cxt_rsp_valid), 64'd1);
    chk("mid_pending", 64'(pending_cnt), 64'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_ready_low", 64'(cxt_combine_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rsp_valid", 64'(cxt_rsp_valid), 64'd0);
    chk("mid_rsp_head", 64'(cxt_rsp_head), 64'd0);
    chk("mid_rsp_data", 64'(|cxt_rsp_data), 64'd0);
    chk("mid_free_valid", 64'(tag_free_valid), 64'd0);
    chk("mid_pending_0", 64'(pending_cnt), 64'd0);
    chk("mid_dup", 64'(dup_tag_err), 64'd0);
    cxt_rsp_ready = 1'b1;
    expect_rsp(0, mk(32'h7777_0000));
    wr(0, mk(32'h7777_0000));
    drain("mid_drain");
    repeat (5) @(negedge clk);
    chk("final_idle", 64'(cxt_rsp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
